// File: rtl/pmod_in.sv
// pmod_in: deserialises a two-channel serial audio stream into left/right words.
// All pins are synchronised into clk. A pair is published only as left followed by right.
module pmod_in #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCLK,
  input  logic             LRCLK,
  input  logic             SDOUT,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             valid,
  output logic             frame_err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, lr_q, sdout_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] shift_q, shift_d, lbuf_q, lbuf_d, left_q, left_d, right_q, right_d, word;
  logic ch_q, ch_d, pend_q, pend_d, valid_q, valid_d, ferr_q, ferr_d;
  logic sclk_rise, lr_edge, shifting, done;
  // [0],[1] synchronise; [2] holds the previous synchronised value
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= '0;
      lr_q    <= '0;
      sdout_q <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], SCLK};
      lr_q    <= {lr_q[1:0], LRCLK};
      sdout_q <= {sdout_q[1:0], SDOUT};
    end
  end
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lr_edge   = lr_q[1] ^ lr_q[2];
  // A channel boundary restarts the word, so a coincident SCLK rise becomes its MSB
  assign cnt_base  = lr_edge ? '0 : cnt_q;
  assign shifting  = sclk_rise & (lr_edge | state_q == SHIFT);
  assign done      = shifting & (cnt_base == CW'(WIDTH - 1));
  assign word      = {shift_q[WIDTH-2:0], sdout_q[2]};
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = done ? HOLD : lr_edge ? SHIFT : state_q;
  end
  always_comb begin
    cnt_d   = shifting ? cnt_base + CW'(1) : cnt_base;
    shift_d = shifting ? word : shift_q;
    ch_d    = lr_edge ? lr_q[1] : ch_q;
    ferr_d  = lr_edge & (state_q == SHIFT);
    valid_d = done & ch_d & pend_q & ~ferr_d;
    pend_d  = done ? ~ch_d : (pend_q & ~ferr_d);
    lbuf_d  = (done & ~ch_d) ? word : lbuf_q;
    left_d  = valid_d ? lbuf_q : left_q;
    right_d = valid_d ? word : right_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      ch_q    <= 1'b0;
      pend_q  <= 1'b0;
      lbuf_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ch_q    <= ch_d;
      pend_q  <= pend_d;
      lbuf_q  <= lbuf_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign left      = left_q;
  assign right     = right_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
endmodule

// File: doc/pmod_in.md
PMOD_IN -- requirements
Module: pmod_in

Interface
REQ-001 Parameter: WIDTH, 16, bits per channel word.
REQ-002 Port: clk  input  1  100MHz system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous to clk, active-high.
REQ-004 Port: SCLK  input  1  external serial bit clock, asynchronous to clk, at most clk/8.
REQ-005 Port: LRCLK  input  1  external channel select: 0 = left word, 1 = right word.
REQ-006 Port: SDOUT  input  1  external serial data, MSB first.
REQ-007 Port: left  output  WIDTH  last complete left sample.
REQ-008 Port: right  output  WIDTH  last complete right sample.
REQ-009 Port: valid  output  1  one-clk pulse when left/right update.
REQ-010 Port: frame_err  output  1  one-clk pulse on a short word.

Function
REQ-011 SCLK, LRCLK and SDOUT SHALL each pass through a 2-flop synchronizer; a third register per signal SHALL hold the previous synchronized value for edge detection.
REQ-012 SCLK rise = synchronized SCLK 1 and previous 0; LRCLK edge = synchronized LRCLK differs from previous value.
REQ-013 Data SHALL be sampled only on an SCLK rise, shifted in MSB first.
REQ-014 State machine with states IDLE, SHIFT, HOLD; reset state IDLE.
REQ-015 IDLE: ignore SCLK; on LRCLK edge -> SHIFT, bit count = 0, channel = new LRCLK value.
REQ-016 SHIFT: each SCLK rise shifts in one bit and increments the count; on the WIDTH-th bit -> HOLD and the word is complete.
REQ-017 HOLD: further SCLK rises are ignored and are not an error; on LRCLK edge -> SHIFT, bit count = 0.
REQ-018 LRCLK edge while in SHIFT (count < WIDTH): pulse frame_err, discard the partial word, clear the left-pending flag, restart SHIFT for the new channel.
REQ-019 Completed left word: store in an internal left buffer and set left-pending; outputs do not change.
REQ-020 Completed right word with left-pending set: left <= left buffer, right <= word, valid pulses, left-pending cleared, all on the same clk edge that captures the final bit.
REQ-021 Completed right word without left-pending: word discarded, no valid, no frame_err.
REQ-022 Same-cycle LRCLK edge and SCLK rise: the word boundary is processed first, and that SCLK rise is the MSB of the new word (count = 1 after that cycle).
REQ-023 Latency: valid asserts exactly 3 clk rising edges after the pin-level SCLK rise carrying the right-channel LSB.
REQ-024 left/right SHALL hold their values between valid pulses; valid and frame_err are never high for more than one consecutive clk.

Reset
REQ-025 While rst is high at a clk edge: left = 0, right = 0, valid = 0, frame_err = 0, state = IDLE, bit count = 0, left-pending = 0, shift and buffer registers = 0.
REQ-026 Synchronizer flops SHALL reset to 0; the previous LRCLK register SHALL reset to 0.
REQ-027 A word in progress when rst deasserts SHALL be discarded silently, with no frame_err, because IDLE waits for the next LRCLK edge.

Verification
REQ-028 Stimulus: SCLK 1MHz, LRCLK toggling every 16 SCLK periods, left 0xA5C3, right 0x1234 -> valid pulses once per frame with left = 0xA5C3, right = 0x1234.
REQ-029 Stimulus: send 16'h8001 left, 16'hFFFF right, then 16'h0000/16'h7FFE -> two valid pulses; outputs change only on the pulses, bit-exact.
REQ-030 Stimulus: LRCLK toggles after only 10 right-channel bits -> one frame_err pulse, no valid for that frame; the next full frame (0x0F0F/0xF0F0) produces valid.
REQ-031 Stimulus: 20 SCLK periods per half-frame, left 0xBEEF, right 0xCAFE -> extra 4 bits ignored, valid with left = 0xBEEF, right = 0xCAFE, no frame_err.
REQ-032 Stimulus: assert rst for 1 clk mid left word, then continue -> outputs 0 immediately after reset, no frame_err, first valid only after a complete left+right pair.
REQ-033 Stimulus: right LSB SCLK rise at pin at clk edge N -> valid high in the cycle following edge N+3, and left/right stable thereafter.
